ps2_keyboard: RTL and testbench

Receive-only PS/2 keyboard interface, mapped as a CPU-bus responder in the IO page. It samples the keyboard's clock/data lines, deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and queues scan-code bytes in a 16-entry FIFO. Software drains the FIFO through a 4-register window selected by `kbd_cs`. An optional level interrupt flags a non-empty FIFO.

---
 rtl/ps2_keyboard_if.sv | 19 +
 rtl/ps2_keyboard.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_if.sv
// CPU IO-page bus bundle for the PS/2 keyboard responder.
// master drives the bus cycle, slave returns read data.
interface ps2_keyboard_if;
  logic       R_W_n;
  logic [1:0] reg_addr_i;
  logic [7:0] data_i;
  logic       kbd_cs;
  logic [7:0] data_o;

  modport master (
    output R_W_n, reg_addr_i, data_i, kbd_cs,
    input  data_o
  );

  modport slave (
    input  R_W_n, reg_addr_i, data_i, kbd_cs,
    output data_o
  );
endinterface

// File: rtl/ps2_keyboard.sv
// Receive-only PS/2 keyboard: deframes scan codes into a FIFO
// drained through a 4-register CPU window, with optional irq.
module ps2_keyboard #(
  parameter int TIMEOUT_CYCLES  = 27000,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  ps2_keyboard_if.slave bus,
  input  logic          ps2_clk_i,
  input  logic          ps2_dat_i,
  output logic          irq_o
);
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PAR, S_STOP
  } st_t;

  logic r_clk_s1, r_clk_s2, r_clk_h;
  logic r_dat_s1, r_dat_s2;
  logic r_edge, r_bit;

  st_t  r_st, w_nxt;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic w_timeout, w_push, w_perr_set, w_ferr_set;

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic r_ovr, r_perr, r_ferr;
  logic r_en, r_ie, r_irq;

  logic w_rd, w_wr, w_pop, w_empty, w_full;
  logic w_wr_stat, w_wr_ctrl, w_flush;
  logic w_fifo_wr, w_ovr_set;
  logic [7:0] w_status, w_count, w_ctrl, w_rdata;
  logic w_unused;

  // Edge pulse and its data bit are registered, giving the push
  // its own cycle after edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_h  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_edge   <= 1'b0;
      r_bit    <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_i;
      r_clk_s2 <= r_clk_s1;
      r_clk_h  <= r_clk_s2;
      r_dat_s1 <= ps2_dat_i;
      r_dat_s2 <= r_dat_s1;
      r_edge   <= r_clk_h & ~r_clk_s2;
      r_bit    <= r_dat_s2;
    end
  end

  assign w_timeout = (r_st != S_IDLE) &&
                     (r_to_cnt == TO_MAX);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_st <= S_IDLE;
    else          r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    if (!r_en || w_timeout) begin
      w_nxt = S_IDLE;
    end else if (r_edge) begin
      unique case (r_st)
        S_IDLE: if (!r_bit) w_nxt = S_DATA;
        S_DATA: if (r_bitcnt == 3'd7) w_nxt = S_PAR;
        S_PAR:  w_nxt = S_STOP;
        S_STOP: w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_push     = 1'b0;
    w_perr_set = 1'b0;
    w_ferr_set = 1'b0;
    if (r_en && w_timeout) begin
      w_ferr_set = 1'b1;
    end else if (r_en && r_edge && r_st == S_STOP) begin
      if (!r_bit)                 w_ferr_set = 1'b1;
      else if (^{r_shift, r_par}) w_push     = 1'b1;
      else                        w_perr_set = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (r_edge || r_st == S_IDLE)
        r_to_cnt <= '0;
      else if (r_to_cnt != TO_MAX)
        r_to_cnt <= r_to_cnt + 1'b1;
      if (r_en && r_edge) begin
        unique case (r_st)
          S_IDLE: r_bitcnt <= '0;
          S_DATA: begin
            r_shift  <= {r_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
          S_PAR:  r_par <= r_bit;
          default: ;
        endcase
      end
    end
  end

  assign w_rd      = bus.kbd_cs & bus.R_W_n;
  assign w_wr      = bus.kbd_cs & ~bus.R_W_n;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_CNT);
  assign w_pop     = w_rd & (bus.reg_addr_i == 2'd0)
                   & ~w_empty;
  assign w_wr_stat = w_wr & (bus.reg_addr_i == 2'd1);
  assign w_wr_ctrl = w_wr & (bus.reg_addr_i == 2'd3);
  assign w_flush   = w_wr_ctrl & bus.data_i[1];
  assign w_fifo_wr = w_push & ~w_flush
                   & (~w_full | w_pop);
  assign w_ovr_set = w_push & ~w_flush
                   & w_full & ~w_pop;
  assign w_unused  = &{1'b0, bus.data_i[7:5]};

  always_ff @(posedge clk_i) begin
    if (w_fifo_wr) r_mem[r_wp] <= r_shift;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_fifo_wr) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      case ({w_fifo_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky flags: a same-cycle set beats a write-1 clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ovr  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_en   <= 1'b1;
      r_ie   <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set |
                (r_ovr & ~(w_wr_stat & bus.data_i[2]));
      r_perr <= w_perr_set |
                (r_perr & ~(w_wr_stat & bus.data_i[3]));
      r_ferr <= w_ferr_set |
                (r_ferr & ~(w_wr_stat & bus.data_i[4]));
      if (w_wr_ctrl) begin
        r_en <= bus.data_i[0];
        r_ie <= bus.data_i[2];
      end
      r_irq <= r_ie & ~w_empty;
    end
  end

  assign irq_o = r_irq;

  assign w_status = {3'b000, r_ferr, r_perr, r_ovr,
                     w_full, ~w_empty};
  assign w_count  = 8'(r_cnt);
  assign w_ctrl   = {5'b00000, r_ie, 1'b0, r_en};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      bus.reg_addr_i == 2'd0:
        w_rdata = w_empty ? 8'h00 : r_mem[r_rp];
      bus.reg_addr_i == 2'd1: w_rdata = w_status;
      bus.reg_addr_i == 2'd2: w_rdata = w_count;
      bus.reg_addr_i == 2'd3: w_rdata = w_ctrl;
    endcase
  end

  assign bus.data_o = bus.kbd_cs ? w_rdata : 8'h00;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: frame-level reference model with
// queue FIFO, checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_ps2_keyboard;
  localparam int TO = 200;
  localparam int H  = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic irq;

  ps2_keyboard_if bus();

  ps2_keyboard #(
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus),
    .ps2_clk_i(ps2_clk),
    .ps2_dat_i(ps2_dat),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] b;
    int         kind;
  } ev_t;

  logic [7:0] mq[$];
  ev_t pend[$];
  bit m_ovr, m_perr, m_ferr, m_en, m_ie, m_irq;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h",
               nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    int n;
    n = mq.size();
    case (a)
      2'd0: return (n != 0) ? mq[0] : 8'h00;
      2'd1: return {3'b000, m_ferr, m_perr, m_ovr,
                    n == 16, n != 0};
      2'd2: return 8'(n);
      default: return {5'b0, m_ie, 1'b0, m_en};
    endcase
  endfunction

  // Reference model: one bus cycle and any frame results
  // landing on this edge are applied per rising clock.
  always @(posedge clk) begin : model
    bit rd, wr, pop, full, flush;
    ev_t ev;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      pend.delete();
      m_ovr = 0; m_perr = 0; m_ferr = 0;
      m_en = 1; m_ie = 0; m_irq = 0;
    end else begin
      rd = bus.kbd_cs & bus.R_W_n;
      wr = bus.kbd_cs & ~bus.R_W_n;
      m_irq = m_ie && (mq.size() != 0);
      full = (mq.size() == 16);
      pop = rd && bus.reg_addr_i == 2'd0 && mq.size() != 0;
      flush = wr && bus.reg_addr_i == 2'd3 && bus.data_i[1];
      if (wr && bus.reg_addr_i == 2'd1) begin
        if (bus.data_i[2]) m_ovr = 0;
        if (bus.data_i[3]) m_perr = 0;
        if (bus.data_i[4]) m_ferr = 0;
      end
      if (pop) void'(mq.pop_front());
      while (pend.size() > 0 && pend[0].due == cyc) begin
        ev = pend.pop_front();
        case (ev.kind)
          0: if (!flush) begin
               if (full && !pop) m_ovr = 1;
               else mq.push_back(ev.b);
             end
          1: m_perr = 1;
          default: m_ferr = 1;
        endcase
      end
      if (flush) mq.delete();
      if (wr && bus.reg_addr_i == 2'd3) begin
        m_en = bus.data_i[0];
        m_ie = bus.data_i[2];
      end
    end
  end

  always begin : compare
    @(posedge clk);
    #1;
    chk("irq", {7'b0, irq}, {7'b0, m_irq});
    if (bus.kbd_cs && bus.R_W_n)
      chk("rdata", bus.data_o, exp_rd(bus.reg_addr_i));
  end

  task automatic bus_idle();
    bus.kbd_cs = 1'b1;
    bus.R_W_n = 1'b1;
    bus.reg_addr_i = 2'd2;
    bus.data_i = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [7:0] v);
    @(negedge clk);
    bus.kbd_cs = 1'b1;
    bus.R_W_n = 1'b1;
    bus.reg_addr_i = a;
    #1 v = bus.data_o;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd2(output logic [7:0] v0,
                     output logic [7:0] v1);
    @(negedge clk);
    bus.kbd_cs = 1'b1;
    bus.R_W_n = 1'b1;
    bus.reg_addr_i = 2'd0;
    #1 v0 = bus.data_o;
    @(negedge clk);
    #1 v1 = bus.data_o;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    bus.kbd_cs = 1'b1;
    bus.R_W_n = 1'b0;
    bus.reg_addr_i = a;
    bus.data_i = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic expect_rd(input string nm,
                           input logic [1:0] a,
                           input logic [7:0] e);
    logic [7:0] v;
    rd(a, v);
    chk(nm, v, e);
  endtask

  // Frame result lands 4 clocks after the stop-bit fall.
  task automatic send(input logic [7:0] b,
                      input bit bad_par,
                      input bit bad_stop,
                      input int nbits,
                      input bit wait_to,
                      input bit pop_at_push,
                      output logic [7:0] popv);
    logic [10:0] f;
    int kind;
    popv = 8'h00;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    kind = bad_stop ? 2 : (bad_par ? 1 : 0);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = f[i];
      repeat (H - 1) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) pend.push_back('{cyc + 4, b, kind});
      for (int k = 0; k < H; k++) begin
        @(negedge clk);
        if (i == 10 && pop_at_push && k == 2) begin
          bus.kbd_cs = 1'b1;
          bus.R_W_n = 1'b1;
          bus.reg_addr_i = 2'd0;
          #1 popv = bus.data_o;
        end
        if (i == 10 && pop_at_push && k == 3) bus_idle();
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    if (wait_to) begin
      repeat (TO + 60) @(negedge clk);
      pend.push_back('{cyc + 1, b, 2});
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] b);
    logic [7:0] d;
    send(b, 0, 0, 11, 0, 0, d);
  endtask

  initial begin : watchdog
    #900us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] v, v1;
    int r;
    bus_idle();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_irq", {7'b0, irq}, 8'h00);
    expect_rd("rst_status", 2'd1, 8'h00);
    expect_rd("rst_count", 2'd2, 8'h00);
    expect_rd("rst_ctrl", 2'd3, 8'h01);
    expect_rd("rst_data", 2'd0, 8'h00);

    good(8'h1C);
    expect_rd("f1c_count", 2'd2, 8'h01);
    expect_rd("f1c_status", 2'd1, 8'h01);
    chk("f1c_irq", {7'b0, irq}, 8'h00);
    expect_rd("f1c_data", 2'd0, 8'h1C);
    expect_rd("f1c_count0", 2'd2, 8'h00);
    expect_rd("f1c_status0", 2'd1, 8'h00);

    wr(2'd3, 8'h05);
    good(8'hF0);
    chk("irq_on", {7'b0, irq}, 8'h01);
    expect_rd("f0_data", 2'd0, 8'hF0);
    repeat (2) @(negedge clk);
    chk("irq_off", {7'b0, irq}, 8'h00);

    for (int i = 0; i <= 16; i++) good(8'(i));
    expect_rd("ovf_count", 2'd2, 8'h10);
    expect_rd("ovf_status", 2'd1, 8'h07);
    for (int i = 0; i < 16; i += 2) begin
      rd2(v, v1);
      chk("ovf_rd_even", v, 8'(i));
      chk("ovf_rd_odd", v1, 8'(i + 1));
    end
    expect_rd("ovf_drained", 2'd1, 8'h04);
    wr(2'd1, 8'h04);
    expect_rd("ovr_clr", 2'd1, 8'h00);

    send(8'h55, 1, 0, 11, 0, 0, v);
    expect_rd("perr_status", 2'd1, 8'h08);
    expect_rd("perr_count", 2'd2, 8'h00);
    wr(2'd1, 8'h08);
    send(8'h33, 0, 1, 11, 0, 0, v);
    expect_rd("stop0_status", 2'd1, 8'h10);
    wr(2'd1, 8'h10);
    send(8'h1F, 0, 0, 6, 1, 0, v);
    expect_rd("to_status", 2'd1, 8'h10);
    wr(2'd1, 8'h10);
    good(8'h2A);
    expect_rd("to_next", 2'd0, 8'h2A);

    for (int i = 0; i < 16; i++) good(8'h30 + 8'(i));
    expect_rd("pp_fill", 2'd2, 8'h10);
    send(8'h40, 0, 0, 11, 0, 1, v);
    chk("pp_popv", v, 8'h30);
    expect_rd("pp_count", 2'd2, 8'h10);
    expect_rd("pp_status", 2'd1, 8'h03);
    wr(2'd3, 8'h03);
    expect_rd("flush_count", 2'd2, 8'h00);
    expect_rd("flush_ctrl", 2'd3, 8'h01);

    good(8'h11);
    send(8'hA5, 0, 0, 6, 0, 0, v);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_irq", {7'b0, irq}, 8'h00);
    expect_rd("mrst_status", 2'd1, 8'h00);
    expect_rd("mrst_count", 2'd2, 8'h00);
    expect_rd("mrst_ctrl", 2'd3, 8'h01);
    good(8'h76);
    expect_rd("mrst_76", 2'd0, 8'h76);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      send(8'($urandom), r == 0, r == 1, 11, 0, 0, v);
      if ($urandom_range(0, 3) == 0)
        wr(2'd3, {5'b0, 1'($urandom_range(0, 1)),
                  1'b0, 1'b1});
      if ($urandom_range(0, 9) == 0)
        wr(2'd3, 8'h03);
      if ($urandom_range(0, 5) == 0)
        wr(2'($urandom_range(0, 1) * 2), 8'($urandom));
      if ($urandom_range(0, 4) == 0)
        wr(2'd1, 8'h1C);
      repeat ($urandom_range(0, 2)) rd(2'd0, v);
      rd(2'd1, v);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
